// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared types and constants for the I2C register target
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    // Bit counter runs 0..9 so it also tracks the two phases of each ACK clock.
    localparam int CNT_W = 4;

    // SDA level that signals acknowledge on the bus.
    localparam logic ACK = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizes one bus line, debounces it and flags edges
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Level flips only after FILT consecutive synchronized samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a small register bank to a bus master and the fabric
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         REG_AW   = 4,
    parameter int         FILT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_drive,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              i2c_wstb,
    output logic [REG_AW-1:0] i2c_waddr,
    output logic [7:0]        i2c_wdata,
    output logic              busy
);

    logic              scl, scl_rise, scl_fall;
    logic              sda, sda_rise, sda_fall;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [7:0]        shreg, sh_n, byte_in, rd_byte;
    logic [REG_AW-1:0] ptr, ptr_n;
    logic              drv_n, busy_n, wr_en, load;
    logic [7:0]        regs [2**REG_AW];

    i2c_line_filter #(.FILT(FILT)) u_scl (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(scl_in),
        .level  (scl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(sda_in),
        .level  (sda),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    assign host_rdata = regs[host_addr];
    assign rd_byte    = regs[ptr];
    assign byte_in    = {shreg[6:0], sda};

    // Bus protocol: data is sampled on SCL rise, SDA drive changes on SCL fall.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        drv_n   = sda_drive;
        busy_n  = busy;
        wr_en   = 1'b0;
        load    = 1'b0;
        if (scl && sda_fall) begin
            state_n = ADDR;
            cnt_n   = '0;
            drv_n   = 1'b0;
        end else if (scl && sda_rise) begin
            state_n = IDLE;
            drv_n   = 1'b0;
            busy_n  = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WDATA: begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_W'(7)) begin
                        if (state == ADDR) begin
                            state_n = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            busy_n  = busy | (byte_in[7:1] == DEV_ADDR);
                        end else if (state == PTR) begin
                            ptr_n   = byte_in[REG_AW-1:0];
                            state_n = PTR_ACK;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr + 1'b1;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                RDATA: cnt_n = cnt + 1'b1;
                RDATA_ACK: begin
                    if (sda == ACK) begin
                        cnt_n = CNT_W'(1);
                    end else begin
                        state_n = IGNORE;
                        drv_n   = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (cnt == CNT_W'(8)) begin
                        drv_n = ~ACK;
                        cnt_n = CNT_W'(9);
                    end else if (cnt == CNT_W'(9)) begin
                        cnt_n   = '0;
                        drv_n   = 1'b0;
                        state_n = (state == ADDR_ACK) ? (shreg[0] ? RDATA : PTR) : WDATA;
                        load    = (state == ADDR_ACK) && shreg[0];
                    end
                end
                RDATA: begin
                    if (cnt == CNT_W'(8)) begin
                        drv_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = RDATA_ACK;
                    end else begin
                        sh_n  = {shreg[6:0], 1'b0};
                        drv_n = ~shreg[6];
                    end
                end
                RDATA_ACK: load = (cnt == CNT_W'(1));
                default: ;
            endcase
        end
        if (load) begin
            sh_n    = rd_byte;
            drv_n   = ~rd_byte[7];
            ptr_n   = ptr + 1'b1;
            cnt_n   = '0;
            state_n = RDATA;
        end
    end

    // Protocol state, shift register, pointer and bus-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_drive <= 1'b0;
            busy      <= 1'b0;
            i2c_wstb  <= 1'b0;
            i2c_waddr <= '0;
            i2c_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= sh_n;
            ptr       <= ptr_n;
            sda_drive <= drv_n;
            busy      <= busy_n;
            i2c_wstb  <= wr_en;
            if (wr_en) begin
                i2c_waddr <= ptr;
                i2c_wdata <= byte_in;
            end
        end
    end

    // Register bank; the I2C write is issued last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (wr_en) regs[ptr] <= byte_in;
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bus-master bench for the I2C register target
module tb_i2c_target_regs;

    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_drive;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       i2c_wstb;
    logic [3:0] i2c_waddr;
    logic [7:0] i2c_wdata;
    logic       busy;
    logic       sda_in;

    int n_cmp = 0;
    int n_err = 0;
    int wcnt = 0;
    int drv_cnt = 0;
    int busy_cnt = 0;
    logic [3:0] wa [8];
    logic [7:0] wd [8];
    logic       coll_hit;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } hv_t;
    hv_t hv [8];

    assign sda_in = sda_m & ~sda_drive;

    i2c_target_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_m),
        .sda_in    (sda_in),
        .sda_drive (sda_drive),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .i2c_wstb  (i2c_wstb),
        .i2c_waddr (i2c_waddr),
        .i2c_wdata (i2c_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i2c_wstb) begin
            if (wcnt < 8) begin
                wa[wcnt] = i2c_waddr;
                wd[wcnt] = i2c_wdata;
            end
            wcnt++;
        end
        if (sda_drive) drv_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        @(negedge clk);
        chk(name, host_rdata, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wt(H);
        scl_m = 1'b1;
        wt(H);
        sda_m = 1'b0;
        wt(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wt(H);
        scl_m = 1'b1;
        wt(H);
        sda_m = 1'b1;
        wt(H);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch, input bit coll, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            if (coll && i == 0) begin
                host_addr  = 4'd2;
                host_wdata = 8'hEE;
                host_we    = 1'b1;
            end
            wt(H);
            scl_m = 1'b1;
            if (glitch > 0 && i == 7) begin
                wt(H / 2);
                scl_m = 1'b0;
                wt(glitch);
                scl_m = 1'b1;
                wt(H / 2 - glitch);
            end else if (coll && i == 0) begin
                for (int k = 0; k < H; k++) begin
                    @(negedge clk);
                    if (i2c_wstb && host_we) begin
                        host_we  = 1'b0;
                        coll_hit = 1'b1;
                    end
                end
                host_we = 1'b0;
                wt(0);
            end else begin
                wt(H);
            end
            scl_m = 1'b0;
        end
        sda_m = 1'b1;
        wt(H);
        scl_m = 1'b1;
        wt(H / 2);
        @(negedge clk);
        ack = sda_in;
        wt(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wt(H);
            scl_m = 1'b1;
            wt(H / 2);
            @(negedge clk);
            b = {b[6:0], sda_in};
            wt(H / 2);
            scl_m = 1'b0;
        end
        sda_m = ack_bit;
        wt(H);
        scl_m = 1'b1;
        wt(H);
        scl_m = 1'b0;
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         wb, db, bb;

        hv[0] = '{1'b1, 4'd5, 8'h3C, 8'h00};
        hv[1] = '{1'b0, 4'd5, 8'h00, 8'h3C};
        hv[2] = '{1'b1, 4'd5, 8'hC3, 8'h3C};
        hv[3] = '{1'b0, 4'd5, 8'h00, 8'hC3};
        hv[4] = '{1'b1, 4'd9, 8'h77, 8'h00};
        hv[5] = '{1'b0, 4'd9, 8'h00, 8'h77};
        hv[6] = '{1'b0, 4'd5, 8'h00, 8'hC3};
        hv[7] = '{1'b0, 4'd0, 8'h00, 8'h00};
        coll_hit = 1'b0;

        wt(3);
        @(negedge clk);
        chk("rst_sda_drive", sda_drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wstb", i2c_wstb, 0);
        rst_n = 1'b1;
        wt(3);

        for (int i = 0; i < 8; i++) begin
            host_we    = hv[i].we;
            host_addr  = hv[i].addr;
            host_wdata = hv[i].wdata;
            @(negedge clk);
            chk($sformatf("host_vec%0d", i), host_rdata, hv[i].exp);
            wt(1);
        end
        host_we = 1'b0;

        wb = wcnt;
        i2c_start();
        send_byte(8'h84, 0, 0, ack); chk("wr_addr_ack", ack, 0);
        send_byte(8'h03, 0, 0, ack); chk("wr_ptr_ack", ack, 0);
        send_byte(8'hA5, 0, 0, ack); chk("wr_d0_ack", ack, 0);
        send_byte(8'h5A, 0, 0, ack); chk("wr_d1_ack", ack, 0);
        wt(2);
        chk("wr_busy", busy, 1);
        i2c_stop();
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_wstb_count", wcnt - wb, 2);
        chk("wr_wstb0_addr", wa[wb], 3);
        chk("wr_wstb0_data", wd[wb], 8'hA5);
        chk("wr_wstb1_addr", wa[wb + 1], 4);
        chk("wr_wstb1_data", wd[wb + 1], 8'h5A);
        rd("wr_reg4", 4'd4, 8'h5A);
        rd("wr_reg3", 4'd3, 8'hA5);

        i2c_start();
        send_byte(8'h84, 0, 0, ack); chk("rd_addr_ack", ack, 0);
        send_byte(8'h03, 0, 0, ack); chk("rd_ptr_ack", ack, 0);
        i2c_start();
        send_byte(8'h85, 0, 0, ack); chk("rd_addr_r_ack", ack, 0);
        recv_byte(1'b0, rb); chk("rd_byte0", rb, 8'hA5);
        recv_byte(1'b1, rb); chk("rd_byte1", rb, 8'h5A);
        db = drv_cnt;
        wt(H);
        i2c_stop();
        chk("rd_nack_released", drv_cnt - db, 0);
        chk("rd_busy_after_stop", busy, 0);

        wb = wcnt; db = drv_cnt; bb = busy_cnt;
        i2c_start();
        send_byte(8'h86, 0, 0, ack); chk("bad_addr_nack", ack, 1);
        send_byte(8'h12, 0, 0, ack); chk("bad_data_nack", ack, 1);
        i2c_stop();
        chk("bad_no_drive", drv_cnt - db, 0);
        chk("bad_no_busy", busy_cnt - bb, 0);
        chk("bad_no_wstb", wcnt - wb, 0);

        i2c_start();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h0F, 0, 0, ack);
        send_byte(8'h11, 0, 0, ack);
        send_byte(8'h22, 0, 0, ack); chk("wrap_ack", ack, 0);
        i2c_stop();
        rd("wrap_reg15", 4'd15, 8'h11);
        rd("wrap_reg0", 4'd0, 8'h22);

        wb = wcnt;
        i2c_start();
        send_byte(8'h84, 2, 0, ack); chk("glitch2_addr_ack", ack, 0);
        send_byte(8'h07, 2, 0, ack); chk("glitch2_ptr_ack", ack, 0);
        send_byte(8'h3E, 0, 0, ack);
        i2c_stop();
        chk("glitch2_wstb_count", wcnt - wb, 1);
        rd("glitch2_reg7", 4'd7, 8'h3E);
        bb = busy_cnt;
        i2c_start();
        send_byte(8'h84, 3, 0, ack); chk("glitch3_counted_nack", ack, 1);
        i2c_stop();
        chk("glitch3_no_busy", busy_cnt - bb, 0);

        i2c_start();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h04, 0, 0, ack);
        i2c_start();
        send_byte(8'h85, 0, 0, ack);
        wt(10);
        @(negedge clk);
        chk("rdata_driving_low", sda_drive, 1);
        rst_n = 1'b0;
        #2;
        chk("reset_releases_sda", sda_drive, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wt(2);
        chk("reset_busy", busy, 0);
        for (int i = 0; i < 16; i++) rd($sformatf("reset_reg%0d", i), 4'(i), 8'h00);
        rst_n = 1'b1;
        wt(3);

        i2c_start();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h02, 0, 0, ack);
        send_byte(8'h6B, 0, 1, ack); chk("coll_ack", ack, 0);
        i2c_stop();
        chk("coll_seen_wstb", coll_hit, 1);
        rd("coll_reg2", 4'd2, 8'h6B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
